control_sequencer: RTL and testbench
====================================

# control_sequencer

Parametrised, fully synchronous multi-cycle control FSM for the simple CPU datapath. It sequences fetch, decode and per-class execute steps and drives the datapath strobes (Gra/Grb/Grc, Rin/Rout, bus-source selects, register enables, memory Read/Write). Memory accesses wait on a Mem_done handshake with a bounded timeout. Illegal opcodes and bus timeouts halt the machine with a cause flag. No delays inside states: every control changes only on a Clock edge.

## Interface
- OPW, 5: opcode width; opcode = IR[IRW-1 -: OPW]
- IRW, 32: instruction register width
- TMO, 15: max wait cycles for Mem_done; 0 disables the timeout
- Clock  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-low reset. One clock; reset is synchronous and active-low.
- IR  in  IRW  current instruction register contents
- Con_FF  in  1  branch condition flag
- Mem_done  in  1  memory access complete, 1-cycle pulse or level
- Stop  in  1  request halt at next instruction boundary
- Gra, Grb, Grc, Rin, Rout  out  1 each  register-file select and strobes
- PCout, MDRout, ZLowout, ZHighout, HIout, LOout, InPortout, Cout, BAout  out  1 each  bus sources
- PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, OutPortin, IncPC  out  1 each  register enables
- Read, Write  out  1 each  memory strobes
- ALU_op  out  OPW  opcode forwarded to ALU, valid while Zin=1
- Run  out  1  high unless halted
- Illegal, Bus_err  out  1 each  sticky halt causes

## Operation
- States: RST, F0, F1, F2, DEC, T3..T7, HALT. Each state asserts its controls for exactly one cycle, except memory states, which hold until Mem_done.
- RST → F0. F0: PCout MARin IncPC Zin. F1 (memory): ZLowout PCin in the first cycle only; Read MDRin held until Mem_done. F2: MDRout IRin. DEC: no strobes; the opcode is decoded → T3 of its class.
- Classes (opcode encodings are shared with the existing ISA):
  - ALU (add sub and or shl shr rol ror): T3 Grb Rout Yin; T4 Grc Rout Zin; T5 ZLowout Gra Rin.
  - IMM (addi andi ori): T3 Grb Rout Yin; T4 Cout Zin; T5 ZLowout Gra Rin.
  - MULDIV: T3 Grb Rout Yin; T4 Grc Rout Zin; T5 ZLowout LOin; T6 ZHighout HIin.
  - UNARY (neg not): T3 Grb Rout Zin; T4 ZLowout Gra Rin.
  - LD: T3 Grb BAout Yin; T4 Cout Zin; T5 ZLowout MARin; T6 (memory) Read MDRin; T7 MDRout Gra Rin.
  - LDI: T3 Grb BAout Yin; T4 Cout Zin; T5 ZLowout Gra Rin.
  - ST: T3–T5 as LD; T6 Gra Rout MDRin; T7 (memory) Write.
  - BR: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout Zin; T6 ZLowout PCin only if Con_FF=1, otherwise no strobes.
  - JR: T3 Gra Rout PCin. JAL: T3 PCout Grb Rin; T4 Gra Rout PCin.
  - MFHI/MFLO: T3 HIout/LOout Gra Rin. IN: T3 InPortout Gra Rin. OUT: T3 Gra Rout OutPortin. NOP: T3 with no strobes.
  - HALT opcode → HALT.
- The last step of every class returns to F0. If Stop=1 at that edge, go to HALT instead.
- Undefined opcode in DEC → HALT with Illegal=1.
- Memory wait: a counter clears on entry to a memory state and increments each cycle Mem_done=0. When it reaches TMO (and TMO≠0), go to HALT with Bus_err=1 and drop Read/Write.
- HALT: all strobes 0, Run=0. Leave only via Reset.

## Timing
- All outputs are registered: they are asserted during the cycle the FSM occupies the state, and change only on the rising edge.
- Reset=0 at an edge forces RST from any state, including mid-memory access. All outputs 0, Illegal=Bus_err=0, Run=1, counter=0.
- Latency with Mem_done on the first cycle: fetch+decode 4 cycles. ALU 7, MULDIV 8, LD 9, ST 9, BR 8, JR 5, JAL 6.
- Each extra Mem_done=0 cycle adds one cycle. Mem_done=1 in the cycle the counter reaches TMO counts as done, not as a timeout.
- Mem_done outside memory states is ignored.
- Stop is sampled only on instruction-final edges.

## Structure
- Package control_pkg: state enum, opcode localparams, class enum, and the opcode→class decode function.
- Sub-module mem_wait_timer (counter, TMO compare, done/timeout outputs), instantiated once.

## Test plan
- Reset, then add (IR[31:27]=00011) with Mem_done tied 1 → F0,F1,F2,DEC,T3,T4,T5,F0 over 7 cycles. Gra&Rin&ZLowout high only in T5. ALU_op=00011 in T4.
- ld with Mem_done held 0 for 3 cycles in T6 → Read=MDRin=1 for 4 cycles, then T7 MDRout Gra Rin; 12 cycles total.
- br with Con_FF=0 vs 1 → PCin high in T6 only when Con_FF=1; both return to F0 after 8 cycles.
- Illegal opcode 11111 → HALT after DEC. Illegal=1, Run=0, all strobes 0, held until Reset.
- TMO=15, Mem_done stuck 0 in F1 → Bus_err=1 and HALT after 15 wait cycles. Reset=0 then clears it and the next state is F0.
- Reset=0 during ST T7 with Write=1 → Write=0 at next edge, state RST; Stop=1 during mul → HALT reached after T6, not earlier.

Source files
------------

// File: rtl/control_pkg.sv
// Shared types for the control sequencer: FSM states, opcode map,
// instruction classes, the strobe bundle and the opcode decoder.
package control_pkg;

  typedef enum logic [3:0] {
    S_RST, S_F0, S_F1, S_F2, S_DEC, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [4:0] {
    C_ALU, C_IMM, C_MULDIV, C_UNARY, C_LD, C_LDI, C_ST, C_BR, C_JR, C_JAL,
    C_MFHI, C_MFLO, C_IN, C_OUT, C_NOP, C_HALT, C_ILL
  } op_class_t;

  // Opcode encodings of the existing ISA; 27..31 are unassigned.
  localparam int unsigned OP_LD   = 0;
  localparam int unsigned OP_LDI  = 1;
  localparam int unsigned OP_ST   = 2;
  localparam int unsigned OP_ADD  = 3;
  localparam int unsigned OP_SUB  = 4;
  localparam int unsigned OP_AND  = 5;
  localparam int unsigned OP_OR   = 6;
  localparam int unsigned OP_SHR  = 7;
  localparam int unsigned OP_SHL  = 8;
  localparam int unsigned OP_ROR  = 9;
  localparam int unsigned OP_ROL  = 10;
  localparam int unsigned OP_ADDI = 11;
  localparam int unsigned OP_ANDI = 12;
  localparam int unsigned OP_ORI  = 13;
  localparam int unsigned OP_MUL  = 14;
  localparam int unsigned OP_DIV  = 15;
  localparam int unsigned OP_NEG  = 16;
  localparam int unsigned OP_NOT  = 17;
  localparam int unsigned OP_BR   = 18;
  localparam int unsigned OP_JR   = 19;
  localparam int unsigned OP_JAL  = 20;
  localparam int unsigned OP_IN   = 21;
  localparam int unsigned OP_OUT  = 22;
  localparam int unsigned OP_MFHI = 23;
  localparam int unsigned OP_MFLO = 24;
  localparam int unsigned OP_NOP  = 25;
  localparam int unsigned OP_HALT = 26;

  typedef struct packed {
    logic gra, grb, grc, rin, rout;
    logic pc_out, mdr_out, zlow_out, zhigh_out, hi_out, lo_out, inport_out, c_out, ba_out;
    logic pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, con_in, outport_in, inc_pc;
    logic read, write;
  } ctl_t;

  function automatic op_class_t decode_op(input int unsigned op);
    op_class_t c;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHL, OP_SHR, OP_ROL, OP_ROR: c = C_ALU;
      OP_ADDI, OP_ANDI, OP_ORI:       c = C_IMM;
      OP_MUL, OP_DIV:                 c = C_MULDIV;
      OP_NEG, OP_NOT:                 c = C_UNARY;
      OP_LD:                          c = C_LD;
      OP_LDI:                         c = C_LDI;
      OP_ST:                          c = C_ST;
      OP_BR:                          c = C_BR;
      OP_JR:                          c = C_JR;
      OP_JAL:                         c = C_JAL;
      OP_MFHI:                        c = C_MFHI;
      OP_MFLO:                        c = C_MFLO;
      OP_IN:                          c = C_IN;
      OP_OUT:                         c = C_OUT;
      OP_NOP:                         c = C_NOP;
      OP_HALT:                        c = C_HALT;
      default:                        c = C_ILL;
    endcase
    return c;
  endfunction

  // Final execute step of each class; single-step classes end in T3.
  function automatic state_t last_step(input op_class_t c);
    state_t s;
    case (c)
      C_ALU, C_IMM, C_LDI: s = S_T5;
      C_MULDIV, C_BR:      s = S_T6;
      C_UNARY, C_JAL:      s = S_T4;
      C_LD, C_ST:          s = S_T7;
      default:             s = S_T3;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer (master) and the datapath (slave).
interface control_sequencer_if #(
  parameter int OPW = 5,
  parameter int IRW = 32
);
  logic [IRW-1:0] IR;
  logic           Con_FF, Mem_done, Stop;
  logic           Gra, Grb, Grc, Rin, Rout;
  logic           PCout, MDRout, ZLowout, ZHighout, HIout, LOout, InPortout, Cout, BAout;
  logic           PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, OutPortin, IncPC;
  logic           Read, Write;
  logic [OPW-1:0] ALU_op;
  logic           Run, Illegal, Bus_err;

  modport master (
    input  IR, Con_FF, Mem_done, Stop,
    output Gra, Grb, Grc, Rin, Rout,
    output PCout, MDRout, ZLowout, ZHighout, HIout, LOout, InPortout, Cout, BAout,
    output PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, OutPortin, IncPC,
    output Read, Write, ALU_op, Run, Illegal, Bus_err
  );

  modport slave (
    output IR, Con_FF, Mem_done, Stop,
    input  Gra, Grb, Grc, Rin, Rout,
    input  PCout, MDRout, ZLowout, ZHighout, HIout, LOout, InPortout, Cout, BAout,
    input  PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, OutPortin, IncPC,
    input  Read, Write, ALU_op, Run, Illegal, Bus_err
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts Mem_done=0 cycles inside a memory state and flags a timeout on the
// TMO-th waiting cycle. A done in that same cycle wins over the timeout.
module mem_wait_timer #(
  parameter int TMO = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy,
  input  logic mem_done,
  output logic done,
  output logic timeout
);
  localparam int CW = (TMO < 2) ? 1 : $clog2(TMO + 1);

  logic [CW-1:0] cnt;
  logic          tmo_hit;

  // Clear outside memory states so every access starts from zero.
  always_ff @(posedge clk) begin
    if (!rst_n || !busy) cnt <= '0;
    else if (!mem_done)  cnt <= cnt + 1'b1;
  end

  generate
    if (TMO == 0) begin : g_no_tmo
      assign tmo_hit = 1'b0;
    end else begin : g_tmo
      assign tmo_hit = (cnt == CW'(TMO - 1));
    end
  endgenerate

  assign done    = busy && mem_done;
  assign timeout = busy && !mem_done && tmo_hit;
endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control FSM: fetch, decode, per-class execute steps.
// Strobes are computed from the next state and registered, so each is
// valid for exactly the cycle the FSM spends in the matching state.
module control_sequencer
  import control_pkg::*;
#(
  parameter int OPW = 5,
  parameter int IRW = 32,
  parameter int TMO = 15
) (
  input logic               Clock,
  input logic               Reset,
  control_sequencer_if.master bus
);
  state_t         state, next_state;
  op_class_t      cls_q, cls_now;
  logic [OPW-1:0] op_ir, op_q, op_now, alu_op_d, alu_op_q;
  ctl_t           ctl_d, ctl_q;
  logic           run_q, illegal_q, bus_err_q;
  logic           mem_busy, mem_done_ok, mem_timeout;

  assign op_ir   = bus.IR[IRW-1 -: OPW];
  assign op_now  = (state == S_DEC) ? op_ir : op_q;
  assign cls_now = (state == S_DEC) ? decode_op(int'(op_ir)) : cls_q;

  assign mem_busy = (state == S_F1) ||
                    (state == S_T6 && cls_q == C_LD) ||
                    (state == S_T7 && cls_q == C_ST);

  mem_wait_timer #(.TMO(TMO)) u_timer (
    .clk      (Clock),
    .rst_n    (Reset),
    .busy     (mem_busy),
    .mem_done (bus.Mem_done),
    .done     (mem_done_ok),
    .timeout  (mem_timeout)
  );

  function automatic ctl_t exec_ctl(input op_class_t c, input state_t s, input logic con);
    ctl_t k;
    k = '0;
    case (c)
      C_ALU, C_IMM, C_MULDIV: begin
        case (s)
          S_T3: begin k.grb = 1'b1; k.rout = 1'b1; k.y_in = 1'b1; end
          S_T4: begin
            k.z_in = 1'b1;
            if (c == C_IMM) k.c_out = 1'b1;
            else begin k.grc = 1'b1; k.rout = 1'b1; end
          end
          S_T5: begin
            k.zlow_out = 1'b1;
            if (c == C_MULDIV) k.lo_in = 1'b1;
            else begin k.gra = 1'b1; k.rin = 1'b1; end
          end
          S_T6: if (c == C_MULDIV) begin k.zhigh_out = 1'b1; k.hi_in = 1'b1; end
          default: ;
        endcase
      end
      C_UNARY: begin
        case (s)
          S_T3:    begin k.grb = 1'b1; k.rout = 1'b1; k.z_in = 1'b1; end
          S_T4:    begin k.zlow_out = 1'b1; k.gra = 1'b1; k.rin = 1'b1; end
          default: ;
        endcase
      end
      C_LD, C_LDI, C_ST: begin
        case (s)
          S_T3: begin k.grb = 1'b1; k.ba_out = 1'b1; k.y_in = 1'b1; end
          S_T4: begin k.c_out = 1'b1; k.z_in = 1'b1; end
          S_T5: begin
            k.zlow_out = 1'b1;
            if (c == C_LDI) begin k.gra = 1'b1; k.rin = 1'b1; end
            else k.mar_in = 1'b1;
          end
          S_T6: begin
            if (c == C_LD) begin k.read = 1'b1; k.mdr_in = 1'b1; end
            else if (c == C_ST) begin k.gra = 1'b1; k.rout = 1'b1; k.mdr_in = 1'b1; end
          end
          S_T7: begin
            if (c == C_LD) begin k.mdr_out = 1'b1; k.gra = 1'b1; k.rin = 1'b1; end
            else if (c == C_ST) k.write = 1'b1;
          end
          default: ;
        endcase
      end
      C_BR: begin
        case (s)
          S_T3:    begin k.gra = 1'b1; k.rout = 1'b1; k.con_in = 1'b1; end
          S_T4:    begin k.pc_out = 1'b1; k.y_in = 1'b1; end
          S_T5:    begin k.c_out = 1'b1; k.z_in = 1'b1; end
          S_T6:    if (con) begin k.zlow_out = 1'b1; k.pc_in = 1'b1; end
          default: ;
        endcase
      end
      C_JR:   if (s == S_T3) begin k.gra = 1'b1; k.rout = 1'b1; k.pc_in = 1'b1; end
      C_JAL: begin
        if (s == S_T3) begin k.pc_out = 1'b1; k.grb = 1'b1; k.rin = 1'b1; end
        if (s == S_T4) begin k.gra = 1'b1; k.rout = 1'b1; k.pc_in = 1'b1; end
      end
      C_MFHI: if (s == S_T3) begin k.hi_out = 1'b1; k.gra = 1'b1; k.rin = 1'b1; end
      C_MFLO: if (s == S_T3) begin k.lo_out = 1'b1; k.gra = 1'b1; k.rin = 1'b1; end
      C_IN:   if (s == S_T3) begin k.inport_out = 1'b1; k.gra = 1'b1; k.rin = 1'b1; end
      C_OUT:  if (s == S_T3) begin k.gra = 1'b1; k.rout = 1'b1; k.outport_in = 1'b1; end
      default: ;
    endcase
    return k;
  endfunction

  // Next-state selection and the strobe set for the state being entered.
  always_comb begin
    next_state = state;
    case (state)
      S_RST:  next_state = S_F0;
      S_F0:   next_state = S_F1;
      S_F1: begin
        if (mem_timeout)      next_state = S_HALT;
        else if (mem_done_ok) next_state = S_F2;
      end
      S_F2:   next_state = S_DEC;
      S_DEC:  next_state = (cls_now == C_ILL || cls_now == C_HALT) ? S_HALT : S_T3;
      S_HALT: next_state = S_HALT;
      default: begin
        if (mem_busy && mem_timeout)         next_state = S_HALT;
        else if (mem_busy && !mem_done_ok)   next_state = state;
        else if (state == last_step(cls_q))  next_state = bus.Stop ? S_HALT : S_F0;
        else                                 next_state = state_t'(state + 4'd1);
      end
    endcase

    ctl_d = '0;
    case (next_state)
      S_F0: begin
        ctl_d.pc_out = 1'b1; ctl_d.mar_in = 1'b1; ctl_d.inc_pc = 1'b1; ctl_d.z_in = 1'b1;
      end
      S_F1: begin
        ctl_d.read = 1'b1; ctl_d.mdr_in = 1'b1;
        // PC update only on the first cycle of the fetch wait.
        if (state != S_F1) begin ctl_d.zlow_out = 1'b1; ctl_d.pc_in = 1'b1; end
      end
      S_F2: begin ctl_d.mdr_out = 1'b1; ctl_d.ir_in = 1'b1; end
      S_T3, S_T4, S_T5, S_T6, S_T7: ctl_d = exec_ctl(cls_now, next_state, bus.Con_FF);
      default: ;
    endcase

    alu_op_d = (ctl_d.z_in && next_state != S_F0) ? op_now : '0;
  end

  // State, registered strobes and sticky halt causes.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state     <= S_RST;
      ctl_q     <= '0;
      alu_op_q  <= '0;
      run_q     <= 1'b1;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state    <= next_state;
      ctl_q    <= ctl_d;
      alu_op_q <= alu_op_d;
      run_q    <= (next_state != S_HALT);
      if (state == S_DEC && cls_now == C_ILL) illegal_q <= 1'b1;
      if (mem_busy && mem_timeout)            bus_err_q <= 1'b1;
    end
  end

  // Opcode and class captured at decode for the execute steps.
  always_ff @(posedge Clock) begin
    if (state == S_DEC) begin
      op_q  <= op_ir;
      cls_q <= cls_now;
    end
  end

  assign bus.Gra       = ctl_q.gra;
  assign bus.Grb       = ctl_q.grb;
  assign bus.Grc       = ctl_q.grc;
  assign bus.Rin       = ctl_q.rin;
  assign bus.Rout      = ctl_q.rout;
  assign bus.PCout     = ctl_q.pc_out;
  assign bus.MDRout    = ctl_q.mdr_out;
  assign bus.ZLowout   = ctl_q.zlow_out;
  assign bus.ZHighout  = ctl_q.zhigh_out;
  assign bus.HIout     = ctl_q.hi_out;
  assign bus.LOout     = ctl_q.lo_out;
  assign bus.InPortout = ctl_q.inport_out;
  assign bus.Cout      = ctl_q.c_out;
  assign bus.BAout     = ctl_q.ba_out;
  assign bus.PCin      = ctl_q.pc_in;
  assign bus.IRin      = ctl_q.ir_in;
  assign bus.MARin     = ctl_q.mar_in;
  assign bus.MDRin     = ctl_q.mdr_in;
  assign bus.Yin       = ctl_q.y_in;
  assign bus.Zin       = ctl_q.z_in;
  assign bus.HIin      = ctl_q.hi_in;
  assign bus.LOin      = ctl_q.lo_in;
  assign bus.CONin     = ctl_q.con_in;
  assign bus.OutPortin = ctl_q.outport_in;
  assign bus.IncPC     = ctl_q.inc_pc;
  assign bus.Read      = ctl_q.read;
  assign bus.Write     = ctl_q.write;
  assign bus.ALU_op    = alu_op_q;
  assign bus.Run       = run_q;
  assign bus.Illegal   = illegal_q;
  assign bus.Bus_err   = bus_err_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: each instruction is expanded by a reference
// model into its expected per-cycle strobe words, then played cycle by cycle.
module tb_control_sequencer;
  localparam int TMO = 15;

  // Strobe bit positions in the observed word.
  localparam logic [26:0] GRA = 27'd1 << 0,  GRB = 27'd1 << 1,  GRC = 27'd1 << 2;
  localparam logic [26:0] RIN = 27'd1 << 3,  ROUT = 27'd1 << 4, PCOUT = 27'd1 << 5;
  localparam logic [26:0] MDROUT = 27'd1 << 6, ZLOW = 27'd1 << 7, ZHIGH = 27'd1 << 8;
  localparam logic [26:0] HIOUT = 27'd1 << 9, LOOUT = 27'd1 << 10, INPOUT = 27'd1 << 11;
  localparam logic [26:0] COUT = 27'd1 << 12, BAOUT = 27'd1 << 13, PCIN = 27'd1 << 14;
  localparam logic [26:0] IRIN = 27'd1 << 15, MARIN = 27'd1 << 16, MDRIN = 27'd1 << 17;
  localparam logic [26:0] YIN = 27'd1 << 18, ZIN = 27'd1 << 19, HIIN = 27'd1 << 20;
  localparam logic [26:0] LOIN = 27'd1 << 21, CONIN = 27'd1 << 22, OUTPIN = 27'd1 << 23;
  localparam logic [26:0] INCPC = 27'd1 << 24, READ = 27'd1 << 25, WRITE = 27'd1 << 26;

  // ISA opcodes.
  localparam int LD = 0, LDI = 1, ST = 2, ADD = 3, SUB = 4, ANDO = 5, ORO = 6, SHR = 7;
  localparam int SHL = 8, ROR = 9, ROL = 10, ADDI = 11, ANDI = 12, ORI = 13, MUL = 14;
  localparam int DIV = 15, NEG = 16, NOTO = 17, BR = 18, JR = 19, JAL = 20, INP = 21;
  localparam int OUTP = 22, MFHI = 23, MFLO = 24, NOP = 25, HALTOP = 26;

  typedef struct {
    logic [26:0] st;
    bit          mem;
    bit          done;
    bit          fin;
    bit          exec;
  } ent_t;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  ent_t q[$];
  bit   exec_f;

  always #5 Clock = ~Clock;

  control_sequencer_if #(.OPW(5), .IRW(32)) bus ();

  control_sequencer #(.OPW(5), .IRW(32), .TMO(TMO)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] strobes();
    return {5'b0, bus.Write, bus.Read, bus.IncPC, bus.OutPortin, bus.CONin, bus.LOin,
            bus.HIin, bus.Zin, bus.Yin, bus.MDRin, bus.MARin, bus.IRin, bus.PCin,
            bus.BAout, bus.Cout, bus.InPortout, bus.LOout, bus.HIout, bus.ZHighout,
            bus.ZLowout, bus.MDRout, bus.PCout, bus.Rout, bus.Rin, bus.Grc, bus.Grb, bus.Gra};
  endfunction

  task automatic push(input logic [26:0] st, input bit fin);
    ent_t e;
    e.st = st; e.mem = 1'b0; e.done = 1'b0; e.fin = fin; e.exec = exec_f;
    q.push_back(e);
  endtask

  // A memory step lasts w+1 cycles, or times out after TMO waiting cycles.
  task automatic push_mem(input logic [26:0] first, input logic [26:0] rest, input int w,
                          input bit fin, output bit to);
    ent_t e;
    int   n;
    n = (w < TMO) ? w : TMO;
    to = (w >= TMO);
    for (int i = 0; i < n; i++) begin
      e.st = (i == 0) ? first : rest; e.mem = 1'b1; e.done = 1'b0; e.fin = 1'b0; e.exec = exec_f;
      q.push_back(e);
    end
    if (!to) begin
      e.st = (n == 0) ? first : rest; e.mem = 1'b1; e.done = 1'b1; e.fin = fin; e.exec = exec_f;
      q.push_back(e);
    end
  endtask

  task automatic do_reset(input string tag);
    Reset = 1'b0; bus.Stop = 1'b0; bus.Mem_done = 1'b0;
    @(negedge Clock);
    chk({tag, " rst_strobes"}, strobes(), 32'd0);
    chk({tag, " rst_run"}, 32'(bus.Run), 32'd1);
    chk({tag, " rst_flags"}, 32'({bus.Illegal, bus.Bus_err}), 32'd0);
    Reset = 1'b1;
  endtask

  // Expand one instruction, play it, and handle a resulting halt.
  // cut >= 0 plays only the first cut cycles and leaves the DUT mid-flight.
  task automatic run_instr(input int op, input bit con, input int wf, input int wm,
                           input bit stop_req, input int cut);
    bit          to, halt, ill, berr;
    logic [31:0] r;
    q.delete(); exec_f = 1'b0; halt = 1'b0; ill = 1'b0; berr = 1'b0;
    push(PCOUT | MARIN | INCPC | ZIN, 1'b0);
    push_mem(ZLOW | PCIN | READ | MDRIN, READ | MDRIN, wf, 1'b0, to);
    if (to) begin
      halt = 1'b1; berr = 1'b1;
    end else begin
      push(MDROUT | IRIN, 1'b0);
      push(27'd0, 1'b0);
      exec_f = 1'b1;
      case (op)
        ADD, SUB, ANDO, ORO, SHL, SHR, ROL, ROR: begin
          push(GRB | ROUT | YIN, 0); push(GRC | ROUT | ZIN, 0); push(ZLOW | GRA | RIN, 1);
        end
        ADDI, ANDI, ORI: begin
          push(GRB | ROUT | YIN, 0); push(COUT | ZIN, 0); push(ZLOW | GRA | RIN, 1);
        end
        MUL, DIV: begin
          push(GRB | ROUT | YIN, 0); push(GRC | ROUT | ZIN, 0); push(ZLOW | LOIN, 0);
          push(ZHIGH | HIIN, 1);
        end
        NEG, NOTO: begin push(GRB | ROUT | ZIN, 0); push(ZLOW | GRA | RIN, 1); end
        LD: begin
          push(GRB | BAOUT | YIN, 0); push(COUT | ZIN, 0); push(ZLOW | MARIN, 0);
          push_mem(READ | MDRIN, READ | MDRIN, wm, 1'b0, to);
          if (to) begin halt = 1'b1; berr = 1'b1; end
          else push(MDROUT | GRA | RIN, 1);
        end
        LDI: begin
          push(GRB | BAOUT | YIN, 0); push(COUT | ZIN, 0); push(ZLOW | GRA | RIN, 1);
        end
        ST: begin
          push(GRB | BAOUT | YIN, 0); push(COUT | ZIN, 0); push(ZLOW | MARIN, 0);
          push(GRA | ROUT | MDRIN, 0);
          push_mem(WRITE, WRITE, wm, 1'b1, to);
          if (to) begin halt = 1'b1; berr = 1'b1; end
        end
        BR: begin
          push(GRA | ROUT | CONIN, 0); push(PCOUT | YIN, 0); push(COUT | ZIN, 0);
          push(con ? (ZLOW | PCIN) : 27'd0, 1);
        end
        JR:     push(GRA | ROUT | PCIN, 1);
        JAL:    begin push(PCOUT | GRB | RIN, 0); push(GRA | ROUT | PCIN, 1); end
        MFHI:   push(HIOUT | GRA | RIN, 1);
        MFLO:   push(LOOUT | GRA | RIN, 1);
        INP:    push(INPOUT | GRA | RIN, 1);
        OUTP:   push(GRA | ROUT | OUTPIN, 1);
        NOP:    push(27'd0, 1);
        HALTOP: halt = 1'b1;
        default: begin halt = 1'b1; ill = 1'b1; end
      endcase
      if (!halt && stop_req) halt = 1'b1;
    end
    if (cut >= 0) begin
      while (q.size() > cut) void'(q.pop_back());
      halt = 1'b0;
    end

    r = $urandom();
    bus.IR = {5'(op), r[26:0]};
    bus.Con_FF = con;
    foreach (q[i]) begin
      @(negedge Clock);
      chk($sformatf("op%0d cyc%0d strobes", op, i), strobes(), 32'(q[i].st));
      chk($sformatf("op%0d cyc%0d run", op, i), 32'(bus.Run), 32'd1);
      chk($sformatf("op%0d cyc%0d flags", op, i), 32'({bus.Illegal, bus.Bus_err}), 32'd0);
      if (q[i].exec && q[i].st[19])
        chk($sformatf("op%0d cyc%0d alu_op", op, i), 32'(bus.ALU_op), 32'(op));
      bus.Mem_done = q[i].mem ? q[i].done : 1'($urandom_range(0, 1));
      bus.Stop = q[i].fin ? stop_req : (stop_req ? 1'b1 : 1'($urandom_range(0, 1)));
    end
    if (halt) begin
      repeat (3) begin
        @(negedge Clock);
        chk($sformatf("op%0d halt strobes", op), strobes(), 32'd0);
        chk($sformatf("op%0d halt run", op), 32'(bus.Run), 32'd0);
        chk($sformatf("op%0d halt flags", op), 32'({bus.Illegal, bus.Bus_err}),
            32'({ill, berr}));
        bus.Mem_done = 1'($urandom_range(0, 1));
        bus.Stop = 1'($urandom_range(0, 1));
      end
      do_reset($sformatf("op%0d halt", op));
    end
  endtask

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 19);
    if (r < 12) return 0;
    if (r < 17) return $urandom_range(1, 4);
    if (r == 17) return TMO - 1;
    if (r == 18) return TMO;
    return TMO + 3;
  endfunction

  initial begin
    int op, wf, wm;
    bit con, stp;
    bus.IR = '0; bus.Con_FF = 1'b0; bus.Mem_done = 1'b0; bus.Stop = 1'b0;
    do_reset("init");

    run_instr(ADD, 1'b0, 0, 0, 1'b0, -1);
    run_instr(LD, 1'b0, 0, 3, 1'b0, -1);
    run_instr(BR, 1'b0, 0, 0, 1'b0, -1);
    run_instr(BR, 1'b1, 0, 0, 1'b0, -1);
    run_instr(MUL, 1'b0, 0, 0, 1'b1, -1);
    run_instr(31, 1'b0, 0, 0, 1'b0, -1);
    run_instr(NOP, 1'b0, TMO + 5, 0, 1'b0, -1);
    run_instr(JAL, 1'b0, 0, 0, 1'b0, -1);
    run_instr(LD, 1'b0, TMO - 1, TMO - 1, 1'b0, -1);
    run_instr(ST, 1'b0, 0, TMO, 1'b0, -1);
    run_instr(ST, 1'b0, 0, 5, 1'b0, 10);
    do_reset("st_abort");
    run_instr(JR, 1'b0, 0, 0, 1'b0, -1);
    run_instr(HALTOP, 1'b0, 0, 0, 1'b0, -1);

    for (int n = 0; n < 200; n++) begin
      op  = $urandom_range(0, 31);
      con = 1'($urandom_range(0, 1));
      wf  = pick_wait();
      wm  = pick_wait();
      stp = ($urandom_range(0, 15) == 0);
      run_instr(op, con, wf, wm, stp, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end
endmodule
